multi_stream_enumerator: RTL and testbench
==========================================

// Module: multi_stream_enumerator
// PURPOSE
//  Tags each element lane of a data stream with a running index (serial) kept per logical stream ID.
//  Lane-exact mode skips lanes with keep=0; the original lane-fixed numbering is still available as a mode.
//  Per-stream counters can be loaded with a base value through a config port.
//  Sits between ingress and tag-consuming stages (scatter, reorder, join), replacing the single-stream enumerator.
//  The output is registered behind a skid buffer, so it can be closed in long pipelines without a timing penalty.
// PARAMETERS
//  data_t        (none)  element type carried per lane
//  NUM_ELEMENTS  8       lanes per beat; power of two, >=1
//  SERIAL_WIDTH  32      tag width in bits; tags wrap modulo 2**SERIAL_WIDTH
//  NUM_STREAMS   4       independent counters, selected by in_stream_id; >=1
//  DENSE         1       1: count only kept lanes; 0: tag = beat_count*NUM_ELEMENTS + lane
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               synchronous active-low reset
//  in             ndata_i.s            #(data_t, NUM_ELEMENTS): data/keep/last/valid/ready
//  in_stream_id   in   $clog2(NUM_STREAMS)  stream of the current in beat; sampled with in.valid
//  out            ntagged_i.m          #(data_t, NUM_ELEMENTS, SERIAL_WIDTH): adds tag[NUM_ELEMENTS]
//  out_stream_id  out  $clog2(NUM_STREAMS)  stream ID travelling with out beat
//  cfg_valid      in   1               load base for cfg_stream (always accepted, no ready)
//  cfg_stream     in   $clog2(NUM_STREAMS)  target stream of the config write
//  cfg_base       in   SERIAL_WIDTH    new base value and restart value for that stream
//  wrap           out  1               1-cycle pulse: an accepted beat's counter update overflowed
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all count[s] and base[s] are cleared to 0; the skid buffer is emptied.
//    Reset values: out.valid=0, in.ready=0 while in reset, wrap=0. Reset mid-packet discards any held beats.
//  - Accept: a beat is accepted when in.valid && in.ready. in.ready=1 whenever the skid slot is empty, so it is registered (no comb path from out.ready).
//  - Latency: exactly 1 cycle from accept to out.valid when the output is free. Throughput is 1 beat/cycle under continuous out.ready.
//  - Per-beat tag computation uses s=in_stream_id and c=count[s] as before the beat:
//     DENSE=1: tag[i] = c + popcount(keep[i-1:0]) for keep[i]=1; tag[i]='0 for keep[i]=0; inc = popcount(keep).
//     DENSE=0: tag[i] = c + i for all lanes; inc = NUM_ELEMENTS (c is a multiple of NUM_ELEMENTS if base is).
//  - Counter update on accept: count[s] <= last ? base[s] : c + inc (mod 2**SERIAL_WIDTH).
//    Non-contiguous keep is legal; a keep=0 beat gives inc=0 but still honours last.
//  - wrap=1 in the cycle after an accept whose unextended c+inc >= 2**SERIAL_WIDTH.
//    A last beat still raises wrap if its tags crossed the wrap point.
//  - Config: on cfg_valid, base[cfg_stream] <= cfg_base and count[cfg_stream] <= cfg_base.
//  - Config and an accepted beat to the same stream in the same cycle:
//     - the beat is tagged with the old count;
//     - the config write wins over the increment and over the last-restart.
//  - Config and beat to different streams in the same cycle are independent.
//  - data, keep, last and stream_id pass through unchanged, aligned with their tags.
//  - out fields are held stable while out.valid && !out.ready (AXI-S rule). No beat is dropped or duplicated.
//  - Skid: if out is stalled while a beat is accepted, that beat goes to the single skid slot and in.ready drops next cycle.
//    Skid and output drain in order.
// STRUCTURE
//  - Shared package libstf_enum_pkg:
//     - serial_t and stream_id_t typedefs;
//     - function popcount_prefix(keep, i) returning the number of kept lanes below i.
//  - Counter/base arrays are flops (NUM_STREAMS*2*SERIAL_WIDTH); no RAM.
//  - One sub-module, tagged_skid_buffer, is natural: a 2-entry register slice carrying {data, keep, last, tag, stream_id}.
//    It owns the in.ready and out.valid logic.
// TESTING
//  - T1, DENSE=1, N=4, stream 0: keep=1111 x2, last on 2nd, then keep=1111 -> tags 0..3, 4..7, 0..3; wrap never.
//  - T2, DENSE=1, N=4: keep=1011 -> tags {0,1,x=0,2}, count 3; next keep=0100 -> lane2 tag 3.
//  - T3, DENSE=0, N=4, cfg base=8 on stream 2, two beats on stream 2 -> lanes 8..11, 12..15; stream 0 still starts at 0.
//  - T4: cfg_base=2**32-2, keep=1111 -> tags FFFFFFFE, FFFFFFFF, 0, 1; wrap pulses 1 cycle.
//  - T5: out.ready held 0 for 5 cycles with continuous in.valid -> exactly 2 beats buffered, in.ready=0.
//    out stays stable; on release the order is preserved, 1 beat/cycle.
//  - T6: the same cycle carries cfg (stream 1, base 100) and a beat on stream 1 with count 5 -> that beat is tagged 5..
//    The next beat is tagged 100.. Reset asserted mid-stall -> out.valid=0 next cycle and all counters are 0.

Source files
------------

// File: rtl/multi_stream_enumerator_pkg.sv
`default_nettype none
// ============================================================================
// Package    : libstf_enum_pkg
// Description: Shared types and helpers for the multi-stream enumerator.
// Revision   : 1.0 - initial release
// ============================================================================
package libstf_enum_pkg;

  localparam int DEF_SERIAL_WIDTH = 32;
  localparam int DEF_NUM_STREAMS  = 4;
  // Widest keep vector the prefix-count helper accepts.
  localparam int MAX_LANES        = 64;

  typedef logic [DEF_SERIAL_WIDTH-1:0]         serial_t;
  typedef logic [$clog2(DEF_NUM_STREAMS)-1:0]  stream_id_t;

  // Number of kept lanes strictly below lane i.
  function automatic logic [7:0] popcount_prefix(input logic [MAX_LANES-1:0] keep,
                                                 input int                   i);
    logic [7:0] cnt;
    cnt = '0;
    for (int j = 0; j < MAX_LANES; j++) begin
      if ((j < i) && keep[j]) cnt = cnt + 8'd1;
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_stream_enumerator_skid.sv
`default_nettype none
// ============================================================================
// Module     : tagged_skid_buffer
// Description: Two-entry register slice (output register + one skid slot).
//              Upstream ready is a flop, so there is no combinational path
//              from out_ready_i to in_ready_o.
// Revision   : 1.0 - initial release
// ============================================================================
module tagged_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_payload_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_payload_o
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             out_free;

  assign in_ready_o    = ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_payload_o = out_q;

  // Next-state: drain skid first, otherwise load the output register, or park a beat when stalled.
  always_comb begin
    accept       = in_valid_i && ready_q;
    out_free     = !out_valid_q || out_ready_i;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_payload_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_payload_i;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; ready reflects whether the skid slot will be empty next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_stream_enumerator.sv
`default_nettype none
// ============================================================================
// Module     : multi_stream_enumerator
// Description: Tags each lane of a beat with a running serial kept per
//              stream ID (dense: kept lanes only; sparse: lane-fixed).
//              Bases are loadable; output is registered behind a skid slot.
// Revision   : 1.0 - initial release
// ============================================================================
module multi_stream_enumerator
  import libstf_enum_pkg::*;
#(
  parameter type data_t        = logic [7:0],
  parameter int  NUM_ELEMENTS  = 8,
  parameter int  SERIAL_WIDTH  = 32,
  parameter int  NUM_STREAMS   = 4,
  parameter int  DENSE         = 1,
  localparam int SID_W         = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  data_t [NUM_ELEMENTS-1:0]                   in_data_i,
  input  logic  [NUM_ELEMENTS-1:0]                   in_keep_i,
  input  logic                                       in_last_i,
  input  logic                                       in_valid_i,
  output logic                                       in_ready_o,
  input  logic  [SID_W-1:0]                          in_stream_id_i,
  output data_t [NUM_ELEMENTS-1:0]                   out_data_o,
  output logic  [NUM_ELEMENTS-1:0]                   out_keep_o,
  output logic                                       out_last_o,
  output logic                                       out_valid_o,
  input  logic                                       out_ready_i,
  output logic  [NUM_ELEMENTS-1:0][SERIAL_WIDTH-1:0] out_tag_o,
  output logic  [SID_W-1:0]                          out_stream_id_o,
  input  logic                                       cfg_valid_i,
  input  logic  [SID_W-1:0]                          cfg_stream_i,
  input  logic  [SERIAL_WIDTH-1:0]                   cfg_base_i,
  output logic                                       wrap_o
);

  localparam int DATA_W    = $bits(data_t) * NUM_ELEMENTS;
  localparam int PAYLOAD_W = DATA_W + NUM_ELEMENTS + 1 + NUM_ELEMENTS * SERIAL_WIDTH + SID_W;

  logic [SERIAL_WIDTH-1:0] count_q [NUM_STREAMS];
  logic [SERIAL_WIDTH-1:0] count_d [NUM_STREAMS];
  logic [SERIAL_WIDTH-1:0] base_q  [NUM_STREAMS];
  logic [SERIAL_WIDTH-1:0] base_d  [NUM_STREAMS];
  logic                    wrap_q;

  logic [MAX_LANES-1:0]                   keep_ext;
  logic [SERIAL_WIDTH-1:0]                cur_count;
  logic [SERIAL_WIDTH-1:0]                inc;
  logic [SERIAL_WIDTH:0]                  sum_ext;
  logic [NUM_ELEMENTS-1:0][SERIAL_WIDTH-1:0] tag;
  logic                                   accept;
  logic [PAYLOAD_W-1:0]                   in_payload;
  logic [PAYLOAD_W-1:0]                   out_payload;

  assign accept = in_valid_i && in_ready_o;
  assign wrap_o = wrap_q;

  // Tag generation from the selected stream's count as it stood before this beat.
  always_comb begin
    keep_ext                   = '0;
    keep_ext[NUM_ELEMENTS-1:0] = in_keep_i;
    cur_count                  = count_q[in_stream_id_i];
    tag                        = '0;
    if (DENSE != 0) begin
      inc = SERIAL_WIDTH'(popcount_prefix(keep_ext, NUM_ELEMENTS));
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if (in_keep_i[i]) tag[i] = cur_count + SERIAL_WIDTH'(popcount_prefix(keep_ext, i));
      end
    end else begin
      inc = SERIAL_WIDTH'(NUM_ELEMENTS);
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        tag[i] = cur_count + SERIAL_WIDTH'(i);
      end
    end
    // Extra MSB captures the overflow that drives the wrap pulse.
    sum_ext = {1'b0, cur_count} + {1'b0, inc};
  end

  // Per-stream counter/base update; a config write overrides both increment and last-restart.
  always_comb begin
    for (int s = 0; s < NUM_STREAMS; s++) begin
      count_d[s] = count_q[s];
      base_d[s]  = base_q[s];
      if (cfg_valid_i && (cfg_stream_i == SID_W'(s))) begin
        base_d[s]  = cfg_base_i;
        count_d[s] = cfg_base_i;
      end else if (accept && (in_stream_id_i == SID_W'(s))) begin
        count_d[s] = in_last_i ? base_q[s] : sum_ext[SERIAL_WIDTH-1:0];
      end
    end
  end

  // Counter/base flops and the one-cycle wrap pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        count_q[s] <= '0;
        base_q[s]  <= '0;
      end
      wrap_q <= 1'b0;
    end else begin
      count_q <= count_d;
      base_q  <= base_d;
      wrap_q  <= accept && sum_ext[SERIAL_WIDTH];
    end
  end

  assign in_payload = {in_data_i, in_keep_i, in_last_i, tag, in_stream_id_i};
  assign {out_data_o, out_keep_o, out_last_o, out_tag_o, out_stream_id_o} = out_payload;

  tagged_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_payload_i  (in_payload),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_payload_o (out_payload)
  );

endmodule
`default_nettype wire

// File: tb/tb_multi_stream_enumerator.sv
`default_nettype none
// ============================================================================
// Module     : tb_multi_stream_enumerator
// Description: Self-checking bench for multi_stream_enumerator (N=4, 32-bit
//              tags, 4 streams); dense instance plus a lane-fixed instance.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_multi_stream_enumerator;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int SW = 2;

  typedef logic [N-1:0][W-1:0] tags_t;

  typedef struct {
    logic [N-1:0][7:0] data;
    logic [N-1:0]      keep;
    logic              last;
    logic [SW-1:0]     sid;
    tags_t             tags;
  } exp_t;

  typedef struct {
    bit          bv;
    logic [1:0]  sid;
    logic [3:0]  keep;
    bit          last;
    bit          cv;
    logic [1:0]  cs;
    logic [31:0] cb;
    tags_t       tags;
    bit          wrap;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N-1:0][7:0] in_data;
  logic [N-1:0]      in_keep;
  logic              in_last, in_valid, in_valid_s;
  logic [SW-1:0]     in_sid;
  logic              cfg_valid;
  logic [SW-1:0]     cfg_stream;
  logic [W-1:0]      cfg_base;
  logic              out_ready;

  logic              in_ready, out_valid, out_last, wrap;
  logic [N-1:0][7:0] out_data;
  logic [N-1:0]      out_keep;
  tags_t             out_tag;
  logic [SW-1:0]     out_sid;

  logic              in_ready_s, out_valid_s, out_last_s, wrap_s;
  logic [N-1:0][7:0] out_data_s;
  logic [N-1:0]      out_keep_s;
  tags_t             out_tag_s;
  logic [SW-1:0]     out_sid_s;

  multi_stream_enumerator #(
    .data_t(logic [7:0]), .NUM_ELEMENTS(N), .SERIAL_WIDTH(W), .NUM_STREAMS(S), .DENSE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_stream_id_i(in_sid),
    .out_data_o(out_data), .out_keep_o(out_keep), .out_last_o(out_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
    .out_stream_id_o(out_sid),
    .cfg_valid_i(cfg_valid), .cfg_stream_i(cfg_stream), .cfg_base_i(cfg_base),
    .wrap_o(wrap)
  );

  multi_stream_enumerator #(
    .data_t(logic [7:0]), .NUM_ELEMENTS(N), .SERIAL_WIDTH(W), .NUM_STREAMS(S), .DENSE(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_keep_i(in_keep), .in_last_i(in_last),
    .in_valid_i(in_valid_s), .in_ready_o(in_ready_s), .in_stream_id_i(in_sid),
    .out_data_o(out_data_s), .out_keep_o(out_keep_s), .out_last_o(out_last_s),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready), .out_tag_o(out_tag_s),
    .out_stream_id_o(out_sid_s),
    .cfg_valid_i(cfg_valid), .cfg_stream_i(cfg_stream), .cfg_base_i(cfg_base),
    .wrap_o(wrap_s)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  logic cur_wrap = 1'b0;
  logic wrap_exp = 1'b0;
  row_t tbl[20];

  // Expected wrap: the wrap value announced for a beat shows up the cycle after it is taken.
  always @(posedge clk) wrap_exp <= (rst_n && in_valid && in_ready) ? cur_wrap : 1'b0;

  function automatic tags_t tg(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic row_t mkrow(bit bv, logic [1:0] sid, logic [3:0] keep, bit last,
                                 bit cv, logic [1:0] cs, logic [31:0] cb, tags_t t, bit w);
    row_t r;
    r.bv = bv; r.sid = sid; r.keep = keep; r.last = last;
    r.cv = cv; r.cs = cs; r.cb = cb; r.tags = t; r.wrap = w;
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Falling edge: scoreboard pop/compare and wrap check.
  task automatic neg();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("wrap", wrap, wrap_exp);
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got tags %h expected none", out_tag);
        end else begin
          e = sb.pop_front();
          chk("tags", out_tag, e.tags);
          chk("meta", {out_data, out_keep, out_last, out_sid}, {e.data, e.keep, e.last, e.sid});
        end
      end
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(logic [1:0] sid, logic [3:0] keep, bit last,
                            logic [N-1:0][7:0] data, bit w);
    in_sid   = sid;
    in_keep  = keep;
    in_last  = last;
    in_data  = data;
    in_valid = 1'b1;
    cur_wrap = w;
  endtask

  task automatic finish_beat(tags_t t, bit cv, logic [1:0] cs, logic [31:0] cb);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      neg();
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      pos();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      e.data = in_data; e.keep = in_keep; e.last = in_last; e.sid = in_sid; e.tags = t;
      sb.push_back(e);
      cfg_valid  = cv;
      cfg_stream = cs;
      cfg_base   = cb;
    end
    pos();
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    cur_wrap  = 1'b0;
  endtask

  task automatic s_beat(logic [1:0] sid, logic [3:0] keep, tags_t t);
    in_sid     = sid;
    in_keep    = keep;
    in_last    = 1'b0;
    in_valid_s = 1'b1;
    neg();
    chk("T3 in_ready", in_ready_s, 1'b1);
    pos();
    in_valid_s = 1'b0;
    neg();
    chk("T3 out_valid", out_valid_s, 1'b1);
    chk("T3 tags", out_tag_s, t);
    pos();
  endtask

  initial begin
    logic [N-1:0][7:0] d;
    int p0;

    tbl[0]  = mkrow(1, 0, 4'b1111, 0, 0, 0, 0, tg(0, 1, 2, 3), 0);
    tbl[1]  = mkrow(1, 0, 4'b1111, 1, 0, 0, 0, tg(4, 5, 6, 7), 0);
    tbl[2]  = mkrow(1, 0, 4'b1111, 0, 0, 0, 0, tg(0, 1, 2, 3), 0);
    tbl[3]  = mkrow(1, 1, 4'b1011, 0, 0, 0, 0, tg(0, 1, 0, 2), 0);
    tbl[4]  = mkrow(1, 1, 4'b0100, 0, 0, 0, 0, tg(0, 0, 3, 0), 0);
    tbl[5]  = mkrow(1, 1, 4'b0000, 1, 0, 0, 0, tg(0, 0, 0, 0), 0);
    tbl[6]  = mkrow(1, 1, 4'b0001, 0, 0, 0, 0, tg(0, 0, 0, 0), 0);
    tbl[7]  = mkrow(1, 0, 4'b1000, 0, 0, 0, 0, tg(0, 0, 0, 4), 0);
    tbl[8]  = mkrow(0, 0, 4'b0000, 0, 1, 3, 32'hFFFF_FFFE, tg(0, 0, 0, 0), 0);
    tbl[9]  = mkrow(1, 3, 4'b1111, 0, 0, 0, 0, tg(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1), 1);
    tbl[10] = mkrow(1, 3, 4'b0011, 1, 0, 0, 0, tg(2, 3, 0, 0), 0);
    tbl[11] = mkrow(1, 3, 4'b0001, 1, 0, 0, 0, tg(32'hFFFF_FFFE, 0, 0, 0), 0);
    tbl[12] = mkrow(1, 3, 4'b1110, 1, 0, 0, 0, tg(0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0), 1);
    tbl[13] = mkrow(0, 0, 4'b0000, 0, 1, 1, 5, tg(0, 0, 0, 0), 0);
    tbl[14] = mkrow(1, 1, 4'b0011, 0, 1, 1, 100, tg(5, 6, 0, 0), 0);
    tbl[15] = mkrow(1, 1, 4'b1111, 0, 0, 0, 0, tg(100, 101, 102, 103), 0);
    tbl[16] = mkrow(1, 1, 4'b1111, 1, 1, 1, 200, tg(104, 105, 106, 107), 0);
    tbl[17] = mkrow(1, 1, 4'b0001, 0, 0, 0, 0, tg(200, 0, 0, 0), 0);
    tbl[18] = mkrow(1, 0, 4'b0001, 0, 1, 2, 50, tg(5, 0, 0, 0), 0);
    tbl[19] = mkrow(1, 2, 4'b0001, 0, 0, 0, 0, tg(50, 0, 0, 0), 0);

    rst_n = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0; in_data = '0; in_keep = '0;
    in_last = 1'b0; in_sid = '0; cfg_valid = 1'b0; cfg_stream = '0; cfg_base = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) pos();
    neg();
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst wrap", wrap, 1'b0);
    pos();
    rst_n = 1'b1;
    neg();
    pos();

    // Lane-fixed instance: base 8 on stream 2, keep ignored; stream 0 untouched
    cfg_valid = 1'b1; cfg_stream = 2'd2; cfg_base = 32'd8;
    neg();
    pos();
    cfg_valid = 1'b0;
    s_beat(2, 4'b1111, tg(8, 9, 10, 11));
    s_beat(2, 4'b0101, tg(12, 13, 14, 15));
    s_beat(0, 4'b1111, tg(0, 1, 2, 3));

    // Table-driven dense vectors with a free output
    for (int r = 0; r < 20; r++) begin
      d = {8'(4 * r + 3), 8'(4 * r + 2), 8'(4 * r + 1), 8'(4 * r)};
      if (tbl[r].bv) begin
        drive_beat(tbl[r].sid, tbl[r].keep, tbl[r].last, d, tbl[r].wrap);
        finish_beat(tbl[r].tags, tbl[r].cv, tbl[r].cs, tbl[r].cb);
      end else begin
        cfg_valid = tbl[r].cv; cfg_stream = tbl[r].cs; cfg_base = tbl[r].cb;
        neg();
        pos();
        cfg_valid = 1'b0;
      end
    end
    neg();
    pos();

    // Output stall with continuous input: two beats held, ready low, output stable
    out_ready = 1'b0;
    drive_beat(0, 4'b1111, 0, 32'hA0A1_A2A3, 0);
    finish_beat(tg(6, 7, 8, 9), 0, 0, 0);
    drive_beat(0, 4'b1111, 0, 32'hB0B1_B2B3, 0);
    finish_beat(tg(10, 11, 12, 13), 0, 0, 0);
    drive_beat(0, 4'b1111, 0, 32'hC0C1_C2C3, 0);
    repeat (5) begin
      neg();
      chk("T5 in_ready", in_ready, 1'b0);
      chk("T5 out_valid", out_valid, 1'b1);
      chk("T5 hold tags", out_tag, tg(6, 7, 8, 9));
      chk("T5 hold data", out_data, 32'hA0A1_A2A3);
      pos();
    end
    out_ready = 1'b1;
    p0 = pops;
    finish_beat(tg(14, 15, 16, 17), 0, 0, 0);
    neg();
    chk("T5 drain rate", pops - p0, 3);
    pos();

    // Reset while stalled with both entries full
    out_ready = 1'b0;
    drive_beat(0, 4'b1111, 0, 32'hD0D1_D2D3, 0);
    finish_beat(tg(18, 19, 20, 21), 0, 0, 0);
    drive_beat(0, 4'b1111, 0, 32'hE0E1_E2E3, 0);
    finish_beat(tg(22, 23, 24, 25), 0, 0, 0);
    rst_n = 1'b0;
    neg();
    pos();
    neg();
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst in_ready", in_ready, 1'b0);
    chk("midrst wrap", wrap, 1'b0);
    pos();
    rst_n = 1'b1;
    neg();
    pos();
    out_ready = 1'b1;

    // Counters and bases are back to zero
    drive_beat(0, 4'b1111, 0, 32'h1011_1213, 0);
    finish_beat(tg(0, 1, 2, 3), 0, 0, 0);
    drive_beat(1, 4'b1111, 1, 32'h2021_2223, 0);
    finish_beat(tg(0, 1, 2, 3), 0, 0, 0);
    drive_beat(1, 4'b0001, 0, 32'h3031_3233, 0);
    finish_beat(tg(0, 0, 0, 0), 0, 0, 0);
    drive_beat(3, 4'b1111, 0, 32'h4041_4243, 0);
    finish_beat(tg(0, 1, 2, 3), 0, 0, 0);
    drive_beat(2, 4'b0011, 0, 32'h5051_5253, 0);
    finish_beat(tg(0, 1, 0, 0), 0, 0, 0);

    for (int n = 0; n < 10; n++) begin
      neg();
      pos();
      if (sb.size() == 0) break;
    end
    chk("drain empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
